wishbone_arbiter: RTL
=====================

// Module: wishbone_arbiter
// PURPOSE
//  Round-robin arbiter sharing one Wishbone peripheral port between pMasters controllers.
//  Uses the shared iWishbone_Ctrl {stb, we, adr, dat} / iWishbone_Peri {ack, dat} types.
//  Sits between the controllers (debug bridge, CPU, DMA) and a single peripheral
//    (e.g. the LED/status block). Classic single-beat cycles only.
// PARAMETERS
//  pMasters   2    number of upstream controllers, >=2
//  pTimeout   255  cycles without ack before forced completion (WB_ARB_TIMEOUT_EN only), >=2
// PORTS
//  clk          in   1                        single clock, all logic on posedge
//  rst_n        in   1                        reset: asynchronous, active-low
//  up_c         in   iWishbone_Ctrl[pMasters] requests from controllers
//  up_p         out  iWishbone_Peri[pMasters] responses to controllers
//  dn_c         out  iWishbone_Ctrl           request to shared peripheral
//  dn_p         in   iWishbone_Peri           response from shared peripheral
//  grant        out  $clog2(pMasters)         index of current/last owner
//  busy         out  1                        a transaction is in progress
//  timeout      out  1                        1-cycle pulse on forced completion
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; grant=pMasters-1, so requester 0 has first priority.
//    Outputs: busy=0, timeout=0, dn_c.stb=0, every up_p[i].ack=0.
//    Reset mid-transaction drops dn_c.stb immediately. No ack is issued for the aborted cycle.
//  FSM IDLE:
//    Scan up_c[i].stb round-robin, starting at grant+1 and wrapping mod pMasters.
//    First hit i: next cycle grant<=i, state<=BUSY.
//    No hit: stay in IDLE; grant holds.
//  FSM BUSY:
//    Drive dn_c = up_c[grant] combinationally (stb passes through).
//    up_p[grant] = dn_p combinationally, so ack reaches the owner in the cycle the
//      peripheral asserts it.
//    Other requesters see ack=0. dn_p.dat is broadcast to all up_p[i].dat.
//    On dn_p.ack: state<=IDLE.
//    If up_c[grant].stb drops before ack (abandoned cycle): state<=IDLE next cycle, no ack routed.
//  Arbitration latency: 1 cycle from stb to dn_c.stb.
//    IDLE lasts at least 1 cycle between transactions, so back-to-back requests alternate fairly.
//  A request arriving while BUSY waits. A lower index wins only if its turn comes first
//    in rotation. No starvation: worst-case wait is pMasters-1 transactions.
//  In IDLE: dn_c.stb=0. dn_c.we/adr/dat = up_c[grant] (don't-care).
//  busy = (state==BUSY).
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//    8-bit-min counter clears on entry to BUSY and increments each BUSY cycle without dn_p.ack.
//    At count==pTimeout-1 without ack: up_p[grant].ack=1 with dat='0 that cycle;
//      timeout=1 for 1 cycle; dn_c.stb forced 0; state<=IDLE.
//    A real ack in the same cycle wins: normal completion, timeout=0.
//  WB_ARB_TIMEOUT_EN undefined: no counter; timeout tied 0; BUSY waits indefinitely for ack.
// STRUCTURE
//  Package wishbone_arb_pkg:
//    typedef enum {IDLE, BUSY} arb_state_e
//    function rr_next(req, last) returning the index of the next requester.
//  iWishbone_Ctrl/Peri stay in the existing shared Wishbone package.
//  Sub-module rr_picker: combinational round-robin priority select (req vector, last -> hit, idx).
//  Reused by future multi-port arbiters.
// TESTING
//  1. Reset, then stb on master0 only. Expect dn_c.stb at cycle+1 and grant=0.
//     Peripheral acks at +3 with dat=8'hA5: up_p[0].ack=1 and dat=A5 same cycle; up_p[1].ack=0.
//  2. Masters 0 and 1 both hold stb continuously; peripheral acks each cycle 1 cycle after stb.
//     Expect grant sequence 0,1,0,1; each ack routed only to the owner.
//  3. Master1 requests while master0 is BUSY. Expect master1 not forwarded until master0 acked.
//     Then master1 granted after exactly one IDLE cycle.
//  4. Master0 drops stb in BUSY with no ack. Expect IDLE next cycle, no ack pulse, and master1
//     (pending) granted.
//  5. rst_n low mid-BUSY. Expect dn_c.stb=0 asynchronously, grant=pMasters-1, busy=0.
//     After release, master0 wins a 0/1 tie.
//  6. WB_ARB_TIMEOUT_EN, pTimeout=4, no ack: owner sees ack with dat=0 and timeout pulses on the
//     4th BUSY cycle, then IDLE.
//     Repeat with ack on that same cycle: normal ack, timeout stays 0.

Source files
------------

// File: rtl/wishbone_arb_pkg.sv
// Arbiter-local types and the round-robin search helper.
// The helper handles up to RR_MAX requesters.
package wishbone_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int RR_MAX = 32;

    // Index of the first set bit of req, searching from last+1 and wrapping mod n.
    // Returns last when nothing is requesting (callers qualify with |req).
    function automatic int rr_next(input logic [RR_MAX-1:0] req, input int last, input int n);
        int   idx;
        logic found;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            if (!found && (k <= n) && req[(last + k) % n]) begin
                idx   = (last + k) % n;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wishbone_pkg.sv
// Shared Wishbone single-beat bus types used by controllers and peripherals.
package wishbone_pkg;

    localparam int WB_AW = 8;
    localparam int WB_DW = 8;

    typedef struct packed {
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } iWishbone_Ctrl;

    typedef struct packed {
        logic             ack;
        logic [WB_DW-1:0] dat;
    } iWishbone_Peri;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select: picks the next requester after i_last.
module rr_picker
    import wishbone_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_hit,
    output logic [IW-1:0] o_idx
);

    logic [RR_MAX-1:0] w_req_ext;
    int                w_pick;

    // Widen the request vector to the helper's width and run the rotating search.
    always_comb begin
        w_req_ext         = '0;
        w_req_ext[N-1:0]  = i_req;
        w_pick            = rr_next(w_req_ext, int'(i_last), N);
    end

    assign o_hit = |i_req;
    assign o_idx = IW'(w_pick);

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone peripheral among pMasters controllers.
// Optional forced completion of stalled cycles: define WB_ARB_TIMEOUT_EN.
module wishbone_arbiter
    import wishbone_pkg::*;
    import wishbone_arb_pkg::*;
#(
    parameter  int pMasters = 2,
    parameter  int pTimeout = 255,
    localparam int GW       = (pMasters > 1) ? $clog2(pMasters) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  iWishbone_Ctrl [pMasters-1:0] up_c,
    output iWishbone_Peri [pMasters-1:0] up_p,
    output iWishbone_Ctrl                dn_c,
    input  iWishbone_Peri                dn_p,
    output logic [GW-1:0]                grant,
    output logic                         busy,
    output logic                         timeout
);

    arb_state_e          r_state;
    logic [GW-1:0]       r_grant;
    logic [pMasters-1:0] w_req;
    logic                w_hit;
    logic [GW-1:0]       w_idx;
    iWishbone_Ctrl       w_own;
    logic                w_busy;
    logic                w_to;
    logic                w_done;

    // Collect strobes into a plain request vector for the picker.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < pMasters; i++) w_req[i] = up_c[i].stb;
    end

    rr_picker #(.N(pMasters)) u_pick (
        .i_req  (w_req),
        .i_last (r_grant),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_own  = up_c[r_grant];
    assign w_busy = (r_state == BUSY);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(pTimeout) > 8) ? $clog2(pTimeout) : 8;
    logic [CW-1:0] r_cnt;

    // Stall counter: held at zero while idle, counts BUSY cycles that see no ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_cnt <= '0;
        else if (!w_busy)       r_cnt <= '0;
        else if (!dn_p.ack)     r_cnt <= r_cnt + CW'(1);
    end

    // A real ack in the final cycle wins; an abandoned cycle is never force-acked.
    assign w_to = w_busy && w_own.stb && !dn_p.ack && (r_cnt == CW'(pTimeout - 1));
`else
    assign w_to = 1'b0;
`endif

    assign w_done = dn_p.ack || !w_own.stb || w_to;

    // Ownership FSM: IDLE always lasts one cycle, which is what makes rotation fair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= GW'(pMasters - 1);
        end else begin
            case (r_state)
                IDLE: if (w_hit) begin
                    r_state <= BUSY;
                    r_grant <= w_idx;
                end
                BUSY: if (w_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Steer the owner to the peripheral and route the response back to the owner only.
    always_comb begin
        dn_c     = w_own;
        dn_c.stb = w_busy && w_own.stb && !w_to;
        for (int i = 0; i < pMasters; i++) begin
            up_p[i].ack = w_busy && (r_grant == GW'(i)) && (dn_p.ack || w_to);
            up_p[i].dat = (w_to && (r_grant == GW'(i))) ? '0 : dn_p.dat;
        end
    end

    assign grant   = r_grant;
    assign busy    = w_busy;
    assign timeout = w_to;

endmodule
